// File: rtl/if_fetch_queue_stage_pkg.sv
// Shared widths, reset address and entry layout for the fetch-queue IF stage.
package if_fetch_queue_stage_pkg;

    localparam int unsigned IF_TO_ID_BUS_WIDTH = 65;
    localparam int unsigned ID_TO_IF_BUS_WIDTH = 33;
    localparam logic [31:0] RESET_PC_DEFAULT   = 32'h1c000000;

    typedef struct packed {
        logic        pred_taken;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        filled;
    } fq_entry_t;

    function automatic logic [31:0] next_fetch_pc(input logic        taken,
                                                  input logic [31:0] target,
                                                  input logic [31:0] pc);
        return taken ? target : pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_fetch_queue.sv
// In-order circular fetch buffer: entries are allocated at request time and
// filled by responses in the same order; the head is handed to ID once filled.
module if_fetch_queue
    import if_fetch_queue_stage_pkg::*;
#(
    parameter int unsigned QUEUE_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          flush,
    input  logic                          alloc,
    input  logic                          alloc_taken,
    input  logic [31:0]                   alloc_pc,
    input  logic                          fill,
    input  logic [31:0]                   fill_inst,
    input  logic                          pop,
    output logic [$clog2(QUEUE_DEPTH):0]  occ,
    output logic [$clog2(QUEUE_DEPTH):0]  pend,
    output logic                          head_valid,
    output logic [IF_TO_ID_BUS_WIDTH-1:0] head_bus
);

    localparam int unsigned AW = $clog2(QUEUE_DEPTH);
    localparam int unsigned CW = AW + 1;

    fq_entry_t     entries [QUEUE_DEPTH];
    logic [AW-1:0] alloc_ptr;
    logic [AW-1:0] fill_ptr;
    logic [AW-1:0] head_ptr;
    logic          do_alloc;
    logic          do_fill;
    logic          do_pop;

    assign head_valid = (occ != '0) && entries[head_ptr].filled;
    assign head_bus   = {entries[head_ptr].pred_taken, entries[head_ptr].pc,
                         entries[head_ptr].inst};

    // pend counts allocated-but-unfilled entries, so a fill never lands on a free slot
    assign do_alloc = alloc && !flush && (occ != CW'(QUEUE_DEPTH));
    assign do_fill  = fill && !flush && (pend != '0);
    assign do_pop   = pop && !flush && head_valid;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
                entries[i] <= '0;
            end
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            occ       <= '0;
            pend      <= '0;
        end else if (flush) begin
            for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
                entries[i].filled <= 1'b0;
            end
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            occ       <= '0;
            pend      <= '0;
        end else begin
            if (do_alloc) begin
                entries[alloc_ptr] <= '{pred_taken: alloc_taken, pc: alloc_pc,
                                        inst: 32'h0, filled: 1'b0};
                alloc_ptr          <= alloc_ptr + AW'(1);
            end
            if (do_fill) begin
                entries[fill_ptr].inst   <= fill_inst;
                entries[fill_ptr].filled <= 1'b1;
                fill_ptr                 <= fill_ptr + AW'(1);
            end
            if (do_pop) begin
                head_ptr <= head_ptr + AW'(1);
            end
            occ  <= occ + CW'(do_alloc) - CW'(do_pop);
            pend <= pend + CW'(do_alloc) - CW'(do_fill);
        end
    end

endmodule

// File: rtl/if_fetch_queue_stage.sv
// IF stage with pipelined instruction-memory requests and an in-order fetch queue;
// redirects flush the queue and squash responses still owed for old requests.
module if_fetch_queue_stage
    import if_fetch_queue_stage_pkg::*;
#(
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT
) (
    input  logic                          clk,
    input  logic                          resetn,
    output logic                          inst_req,
    output logic [31:0]                   inst_addr,
    input  logic                          inst_addr_ok,
    input  logic                          inst_data_ok,
    input  logic [31:0]                   inst_rdata,
    output logic [31:0]                   fetch_pc,
    input  logic                          pred_taken,
    input  logic [31:0]                   pred_target,
    input  logic                          redirect_valid,
    input  logic [31:0]                   redirect_pc,
    input  logic                          id_allow_in,
    output logic                          if_to_id_valid,
    output logic [IF_TO_ID_BUS_WIDTH-1:0] if_to_id_bus
);

    localparam int unsigned CW        = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_EXT = (CW + 1)'(QUEUE_DEPTH);

    logic [ID_TO_IF_BUS_WIDTH-1:0] id_to_if_bus;
    logic                          redir;
    logic [31:0]                   redir_pc;
    logic [31:0]                   pc_q;
    logic [CW-1:0]                 discard_q;
    logic [CW-1:0]                 occ;
    logic [CW-1:0]                 pend;
    logic [CW:0]                   in_flight;
    logic                          accept;
    logic                          fill;
    logic                          pop;

    assign id_to_if_bus = {redirect_valid, redirect_pc};
    assign redir        = id_to_if_bus[32];
    assign redir_pc     = id_to_if_bus[31:0];

    assign fetch_pc  = pc_q;
    assign inst_addr = pc_q;

    // Squashed-but-owed responses hold slots too, so the queue can never be overrun
    assign in_flight = {1'b0, occ} + {1'b0, discard_q};
    assign inst_req  = resetn && !redir && (in_flight < DEPTH_EXT);
    assign accept    = inst_req && inst_addr_ok;
    assign fill      = inst_data_ok && (discard_q == '0);
    assign pop       = if_to_id_valid && id_allow_in;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_q      <= RESET_PC;
            discard_q <= '0;
        end else if (redir) begin
            pc_q      <= redir_pc;
            discard_q <= discard_q + pend - CW'(inst_data_ok);
        end else begin
            if (accept) begin
                pc_q <= next_fetch_pc(pred_taken, pred_target, pc_q);
            end
            if (inst_data_ok && (discard_q != '0)) begin
                discard_q <= discard_q - CW'(1);
            end
        end
    end

    if_fetch_queue #(
        .QUEUE_DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk         (clk),
        .resetn      (resetn),
        .flush       (redir),
        .alloc       (accept),
        .alloc_taken (pred_taken),
        .alloc_pc    (pc_q),
        .fill        (fill),
        .fill_inst   (inst_rdata),
        .pop         (pop),
        .occ         (occ),
        .pend        (pend),
        .head_valid  (if_to_id_valid),
        .head_bus    (if_to_id_bus)
    );

endmodule

// File: tb/tb_if_fetch_queue_stage.sv
// Scoreboard bench: an issue process records accepted fetches and a memory model,
// a monitor process checks every instruction ID consumes against that record.
module tb_if_fetch_queue_stage;

    localparam int unsigned DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h1c000000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_allow_in;
    logic        if_to_id_valid;
    logic [64:0] if_to_id_bus;

    always #5 clk = ~clk;

    if_fetch_queue_stage #(
        .QUEUE_DEPTH (DEPTH),
        .RESET_PC    (RST_PC)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .inst_req       (inst_req),
        .inst_addr      (inst_addr),
        .inst_addr_ok   (inst_addr_ok),
        .inst_data_ok   (inst_data_ok),
        .inst_rdata     (inst_rdata),
        .fetch_pc       (fetch_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_allow_in    (id_allow_in),
        .if_to_id_valid (if_to_id_valid),
        .if_to_id_bus   (if_to_id_bus)
    );

    // Instructions ID is owed, oldest first; filled once their response has arrived
    typedef struct { logic taken; logic [31:0] pc; logic filled; } exp_t;
    // Requests the memory still has to answer, in order
    typedef struct { logic [31:0] addr; int ready; logic squashed; } mem_t;

    exp_t exp_q[$];
    mem_t mem_q[$];

    int n_checks  = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int delivered = 0;
    bit run       = 1'b0;

    int p_addr_ok, p_data_ok, max_lat, p_redirect, p_taken, p_allow;

    logic [31:0] model_pc;
    logic        fill_now;
    logic        redir_now;
    logic [31:0] redir_pc_now;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {pc[15:0], ~pc[31:16]} ^ 32'h0f0f3c3c;
    endfunction

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic knobs(input int a, input int d, input int l, input int r, input int t,
                         input int al);
        p_addr_ok = a; p_data_ok = d; max_lat = l; p_redirect = r; p_taken = t; p_allow = al;
    endtask

    task automatic drive();
        inst_addr_ok   = ($urandom_range(99) < p_addr_ok);
        inst_data_ok   = 1'b0;
        inst_rdata     = $urandom;
        if (mem_q.size() > 0 && mem_q[0].ready <= cyc && $urandom_range(99) < p_data_ok) begin
            inst_data_ok = 1'b1;
            inst_rdata   = inst_of(mem_q[0].addr);
        end
        redirect_valid = ($urandom_range(99) < p_redirect);
        redirect_pc    = {16'h1c00, 14'($urandom), 2'b00};
        pred_taken     = ($urandom_range(99) < p_taken);
        pred_target    = {16'h1c00, 14'($urandom), 2'b00};
        id_allow_in    = ($urandom_range(99) < p_allow);
    endtask

    task automatic run_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            cyc++;
            #1;
            drive();
        end
    endtask

    task automatic quiet_inputs();
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;
        pred_taken = 1'b0; pred_target = '0; redirect_valid = 1'b0; redirect_pc = '0;
        id_allow_in = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, " inst_req"}, inst_req, 1'b0);
        chk({tag, " if_to_id_valid"}, if_to_id_valid, 1'b0);
        chk({tag, " if_to_id_bus"}, if_to_id_bus, 65'h0);
        chk({tag, " fetch_pc"}, fetch_pc, RST_PC);
    endtask

    task automatic release_reset();
        @(posedge clk);
        cyc++;
        #1;
        exp_q.delete();
        mem_q.delete();
        model_pc = RST_PC;
        resetn   = 1'b1;
        run      = 1'b1;
        drive();
    endtask

    // Issue side: request expectation, accepts, responses, then redirects after the monitor
    always @(negedge clk) begin
        if (run) begin
            int   squashed;
            logic exp_req;
            logic acc;
            squashed = 0;
            foreach (mem_q[i]) if (mem_q[i].squashed) squashed++;
            exp_req = !redirect_valid && (exp_q.size() + squashed < int'(DEPTH));
            chk("inst_req", inst_req, exp_req);
            if (exp_req) chk("inst_addr", inst_addr, model_pc);
            acc      = exp_req && inst_addr_ok;
            fill_now = 1'b0;
            if (inst_data_ok && mem_q.size() > 0) begin
                fill_now = !mem_q[0].squashed;
                void'(mem_q.pop_front());
            end
            if (acc) begin
                exp_q.push_back('{taken: pred_taken, pc: model_pc, filled: 1'b0});
                mem_q.push_back('{addr: model_pc, ready: cyc + 1 + $urandom_range(0, max_lat),
                                  squashed: 1'b0});
                model_pc = pred_taken ? pred_target : model_pc + 32'd4;
            end
            redir_now    = redirect_valid;
            redir_pc_now = redirect_pc;
            #2;
            if (fill_now) begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    if (!exp_q[i].filled) begin
                        exp_q[i].filled = 1'b1;
                        break;
                    end
                end
            end
            if (redir_now) begin
                exp_q.delete();
                foreach (mem_q[i]) mem_q[i].squashed = 1'b1;
                model_pc = redir_pc_now;
            end
        end
    end

    // Monitor: whatever ID takes this cycle must be the oldest owed instruction
    always @(negedge clk) begin
        if (run) begin
            logic ev;
            #1;
            ev = (exp_q.size() > 0) && exp_q[0].filled;
            chk("if_to_id_valid", if_to_id_valid, ev);
            if (ev && id_allow_in) begin
                chk("if_to_id_bus", if_to_id_bus,
                    {exp_q[0].taken, exp_q[0].pc, inst_of(exp_q[0].pc)});
                void'(exp_q.pop_front());
                delivered++;
            end
        end
    end

    initial begin
        resetn = 1'b0;
        quiet_inputs();
        knobs(100, 100, 0, 0, 0, 100);
        #12;
        check_reset_state("reset");

        // Back-to-back stream with single-cycle memory
        release_reset();
        run_cycles(30);
        // ID stalled: queue fills and requests stop until ID drains it
        knobs(100, 100, 0, 0, 0, 0);
        run_cycles(12);
        knobs(100, 100, 0, 0, 0, 100);
        run_cycles(10);
        // Predicted-taken fetches
        knobs(100, 100, 0, 0, 30, 100);
        run_cycles(40);
        // Random handshakes, latencies and redirects
        knobs(70, 60, 4, 10, 25, 70);
        run_cycles(3000);
        knobs(100, 100, 0, 0, 0, 100);
        run_cycles(20);
        chk("instructions delivered", 32'(delivered > 500), 32'd1);

        // Reset in the middle of traffic
        knobs(80, 80, 3, 0, 20, 50);
        run_cycles(15);
        @(posedge clk);
        cyc++;
        #1;
        run    = 1'b0;
        resetn = 1'b0;
        quiet_inputs();
        #1;
        check_reset_state("mid reset");
        knobs(100, 100, 0, 0, 0, 100);
        release_reset();
        run_cycles(25);

        run = 1'b0;
        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
